// File: rtl/lsu_seq_if.sv
// Data-memory request/acknowledge bus between the load/store sequencer and data memory.
// The sequencer is the master; it holds mem_req until mem_ack or its own timeout.
interface lsu_seq_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/lsu_seq.sv
// Pointer-based load/store sequencer: one byte access at {ptr_hi,ptr_lo}, then a register-file
// write-back and optional pointer-pair post-increment/decrement strobe.
module lsu_seq #(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [1:0]        post_mode,
  input  logic [3:0]        ptr_sel,
  input  logic [3:0]        dest_sel,
  input  logic [7:0]        ptr_hi,
  input  logic [7:0]        ptr_lo,
  input  logic [7:0]        store_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  lsu_seq_if.master         mem,
  output logic              rf_write_en,
  output logic [3:0]        rf_in_select,
  output logic [7:0]        rf_in,
  output logic              rf_inc,
  output logic              rf_dec,
  output logic [3:0]        rf_pair_sel
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WB, FAIL} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [15:0]        addr_q;
  logic [7:0]         wdata_q, rdata_q;
  logic [3:0]         ptr_q, dest_q;
  logic [1:0]         pm_q;
  logic               store_q;
  logic               timeout_hit, hazard;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
  // A load into either half of the pointer pair overrides the post-modify of that pair.
  assign hazard      = !store_q && (dest_q[3:1] == ptr_q[3:1]);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the capture registers are few and feed outputs directly, so they are reset to keep outputs 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ptr_q   <= '0;
      dest_q  <= '0;
      pm_q    <= '0;
      store_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          cnt_q   <= '0;
          addr_q  <= {ptr_hi, ptr_lo};
          wdata_q <= store_data;
          ptr_q   <= ptr_sel;
          dest_q  <= dest_sel;
          pm_q    <= post_mode;
          store_q <= is_store;
        end
        REQ: begin
          if (mem.mem_ack) rdata_q <= mem.mem_rdata;
          else             cnt_q   <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = ptr_sel[0] ? FAIL : REQ;
      REQ: begin
        if (mem.mem_ack)      state_d = WB;
        else if (timeout_hit) state_d = FAIL;
      end
      WB:      state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != IDLE);
    done          = (state_q == WB) || (state_q == FAIL);
    err           = (state_q == FAIL);
    mem.mem_req   = (state_q == REQ);
    mem.mem_we    = (state_q == REQ) && store_q;
    mem.mem_addr  = addr_q;
    mem.mem_wdata = wdata_q;
    rf_write_en   = (state_q == WB) && !store_q;
    rf_inc        = (state_q == WB) && (pm_q == 2'b01) && !hazard;
    rf_dec        = (state_q == WB) && (pm_q == 2'b10) && !hazard;
    rf_in_select  = dest_q;
    rf_in         = rdata_q;
    rf_pair_sel   = ptr_q;
  end

endmodule

// File: tb/tb_lsu_seq.sv
// Directed bench for lsu_seq: loads, stores, timeout, odd pointer, hazard, ignored start, reset mid-op.
module tb_lsu_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, is_store = 1'b0;
  logic [1:0] post_mode = '0;
  logic [3:0] ptr_sel = '0, dest_sel = '0;
  logic [7:0] ptr_hi = '0, ptr_lo = '0, store_data = '0;
  logic       busy, done, err, rf_write_en, rf_inc, rf_dec;
  logic [3:0] rf_in_select, rf_pair_sel;
  logic [7:0] rf_in;

  lsu_seq_if mif ();

  lsu_seq #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .post_mode(post_mode),
    .ptr_sel(ptr_sel), .dest_sel(dest_sel), .ptr_hi(ptr_hi), .ptr_lo(ptr_lo),
    .store_data(store_data), .busy(busy), .done(done), .err(err), .mem(mif.master),
    .rf_write_en(rf_write_en), .rf_in_select(rf_in_select), .rf_in(rf_in),
    .rf_inc(rf_inc), .rf_dec(rf_dec), .rf_pair_sel(rf_pair_sel)
  );

  always #5 clk = ~clk;

  int n_errors = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: acks after ack_wait request cycles, never when ack_en is 0.
  int         ack_wait = 0;
  bit         ack_en = 1'b1;
  logic [7:0] mem_val = '0;

  initial begin
    int wait_cnt = 0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mif.mem_ack = 1'b0;
      if (mif.mem_req && ack_en) begin
        if (wait_cnt == ack_wait) begin
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = mem_val;
          wait_cnt      = 0;
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  // Observations of the most recent operation, cycles counted from the start edge.
  int          done_at, req_cnt;
  logic        o_err, o_wr, o_inc, o_dec, o_both, o_we, o_busy1;
  logic [7:0]  o_rf_in, o_wdata;
  logic [3:0]  o_sel, o_pair;
  logic [15:0] o_addr;

  task automatic run_op(input bit st, input logic [1:0] pm, input logic [3:0] ps, input logic [3:0] ds,
                        input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] sd,
                        input int wait_n, input bit ack_on, input logic [7:0] rd, input bit second_start);
    ack_wait = wait_n; ack_en = ack_on; mem_val = rd;
    done_at = -1; req_cnt = 0;
    o_err = 0; o_wr = 0; o_inc = 0; o_dec = 0; o_both = 0; o_we = 0; o_busy1 = 0;
    o_rf_in = '0; o_wdata = '0; o_sel = '0; o_pair = '0; o_addr = '0;
    @(posedge clk); #1;
    is_store = st; post_mode = pm; ptr_sel = ps; dest_sel = ds;
    ptr_hi = hi; ptr_lo = lo; store_data = sd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (second_start && k == 1) begin
        start = 1'b1; is_store = 1'b1; ptr_sel = 4'd4; ptr_hi = 8'h55; ptr_lo = 8'h66;
      end else start = 1'b0;
      if (k == 1) o_busy1 = busy;
      if (mif.mem_req) begin
        req_cnt++;
        o_addr = mif.mem_addr; o_we = mif.mem_we; o_wdata = mif.mem_wdata;
      end
      if (rf_write_en) begin o_wr = 1'b1; o_rf_in = rf_in; o_sel = rf_in_select; end
      if (rf_inc || rf_dec) o_pair = rf_pair_sel;
      o_inc  |= rf_inc;
      o_dec  |= rf_dec;
      o_both |= (rf_inc && rf_dec);
      if (done) begin done_at = k; o_err = err; break; end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    logic any_busy, any_done, any_req;
    #12 rst_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", mif.mem_req, 0);
    check("rst_addr", mif.mem_addr, 0);
    check("rst_rf", {rf_write_en, rf_inc, rf_dec, err}, 0);

    // Load r3:r2=0x12FF -> r7, post-increment, immediate ack.
    run_op(0, 2'b01, 4'd2, 4'd7, 8'h12, 8'hFF, 8'h00, 0, 1, 8'hA5, 0);
    check("ld_done_at", done_at, 2);
    check("ld_busy", o_busy1, 1);
    check("ld_req_cnt", req_cnt, 1);
    check("ld_addr", o_addr, 16'h12FF);
    check("ld_we", o_we, 0);
    check("ld_wr", o_wr, 1);
    check("ld_rf_in", o_rf_in, 8'hA5);
    check("ld_sel", o_sel, 4'd7);
    check("ld_inc_dec", {o_inc, o_dec}, 2'b10);
    check("ld_pair", o_pair, 4'd2);
    check("ld_err", o_err, 0);

    // Store 0x3C to r1:r0=0x0000, post-decrement, ack after 3 waits.
    run_op(1, 2'b10, 4'd0, 4'd0, 8'h00, 8'h00, 8'h3C, 3, 1, 8'h00, 0);
    check("st_done_at", done_at, 5);
    check("st_req_cnt", req_cnt, 4);
    check("st_we", o_we, 1);
    check("st_wdata", o_wdata, 8'h3C);
    check("st_addr", o_addr, 16'h0000);
    check("st_wr", o_wr, 0);
    check("st_inc_dec", {o_inc, o_dec}, 2'b01);
    check("st_err", o_err, 0);

    // No ack: 16 request cycles then error.
    run_op(0, 2'b01, 4'd4, 4'd1, 8'hAB, 8'hCD, 8'h00, 0, 0, 8'h00, 0);
    check("to_req_cnt", req_cnt, 16);
    check("to_done_at", done_at, 17);
    check("to_err", o_err, 1);
    check("to_strobes", {o_wr, o_inc, o_dec}, 0);

    // Odd pointer select: immediate error, no memory request.
    run_op(0, 2'b01, 4'd5, 4'd1, 8'h10, 8'h20, 8'h00, 0, 1, 8'h77, 0);
    check("odd_done_at", done_at, 1);
    check("odd_req_cnt", req_cnt, 0);
    check("odd_err", o_err, 1);
    check("odd_strobes", {o_wr, o_inc, o_dec}, 0);

    // Hazard: load into r9 of pair r9:r8 suppresses the increment; extra start is ignored.
    run_op(0, 2'b01, 4'd8, 4'd9, 8'h40, 8'h00, 8'h00, 1, 1, 8'h5A, 1);
    check("hz_done_at", done_at, 3);
    check("hz_req_cnt", req_cnt, 2);
    check("hz_addr", o_addr, 16'h4000);
    check("hz_wr", o_wr, 1);
    check("hz_rf_in", o_rf_in, 8'h5A);
    check("hz_inc_dec", {o_inc, o_dec}, 0);
    any_busy = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      any_busy |= busy;
    end
    check("hz_ignored_start", any_busy, 0);

    // Hazard on post-decrement: load r1 via pair r1:r0.
    run_op(0, 2'b10, 4'd0, 4'd1, 8'hFF, 8'hFF, 8'h00, 0, 1, 8'hC3, 0);
    check("hz2_wr", o_wr, 1);
    check("hz2_inc_dec", {o_inc, o_dec}, 0);

    // post_mode=11 is treated as none.
    run_op(0, 2'b11, 4'd6, 4'd2, 8'h01, 8'h02, 8'h00, 0, 1, 8'h99, 0);
    check("pm11_inc_dec", {o_inc, o_dec}, 0);
    check("pm11_sel", o_sel, 4'd2);

    // Reset while in REQ.
    ack_en = 0;
    @(posedge clk); #1;
    is_store = 0; ptr_sel = 4'd2; ptr_hi = 8'h11; ptr_lo = 8'h22; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rr_req_before", mif.mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("rr_req_async", mif.mem_req, 0);
    check("rr_busy", busy, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    any_done = 0; any_req = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      any_done |= done;
      any_req  |= mif.mem_req | rf_write_en | rf_inc | rf_dec;
    end
    check("rr_no_done", any_done, 0);
    check("rr_no_activity", any_req, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
